// File: rtl/pll_phase_sequencer.sv
// ECP5 EHXPLLL supervisor: drives PLL RST, debounces LOCK into clk_good and
// issues dynamic phase-step sequences on PHASESEL/PHASEDIR/PHASESTEP.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_PLL_RST  | pll_rst asserted for RST_PULSE_CYCLES
// ST_WAIT_LOCK| waiting for LOCK_STABLE_CYCLES consecutive locked cycles
// ST_IDLE     | clock good, accepting phase-shift requests
// ST_SETUP    | phasesel/phasedir settling before the first pulse
// ST_STEP     | phasestep high for STEP_HIGH cycles
// ST_GAP      | phasestep low for STEP_GAP cycles, then next step or done
module pll_phase_sequencer #(
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STEP_SETUP         = 4,
  parameter int STEP_HIGH          = 4,
  parameter int STEP_GAP           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_count,
  output logic       done,
  output logic       busy,
  output logic       clk_good,
  output logic [7:0] lock_loss_cnt
);

  localparam int TMAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int TMAX_B = (STEP_SETUP > STEP_HIGH) ? STEP_SETUP : STEP_HIGH;
  localparam int TMAX_C = (TMAX_B > STEP_GAP) ? TMAX_B : STEP_GAP;
  localparam int TMAX   = (TMAX_A > TMAX_C) ? TMAX_A : TMAX_C;
  localparam int TW     = $clog2(TMAX + 1);

  // Timer load values; every phase ends on the cycle the timer reads zero.
  // The lock timer loads the full count so clk_good follows the stable
  // window by one extra registered cycle.
  localparam logic [TW-1:0] T_RST   = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] T_SETUP = TW'(STEP_SETUP - 1);
  localparam logic [TW-1:0] T_HIGH  = TW'(STEP_HIGH - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(STEP_GAP - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_GAP
  } state_t;

  state_t          state, state_n;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic            lock_lost;
  logic [TW-1:0]   timer, timer_n;
  logic [7:0]      remain, remain_n;
  logic [1:0]      sel_n;
  logic            dir_n;
  logic            done_n;
  logic [7:0]      llc_n;

  assign lock_s    = sync_q[1];
  assign pll_rst   = (state == ST_PLL_RST);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_SETUP) || (state == ST_STEP) || (state == ST_GAP);
  assign clk_good  = req_ready || busy;
  assign phasestep = (state == ST_STEP);
  assign lock_lost = clk_good && !lock_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 2'b00;
      state         <= ST_PLL_RST;
      timer         <= T_RST;
      remain        <= 8'd0;
      phasesel      <= 2'b00;
      phasedir      <= 1'b0;
      done          <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      sync_q        <= {sync_q[0], pll_locked};
      state         <= state_n;
      timer         <= timer_n;
      remain        <= remain_n;
      phasesel      <= sel_n;
      phasedir      <= dir_n;
      done          <= done_n;
      lock_loss_cnt <= llc_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    remain_n = remain;
    sel_n    = phasesel;
    dir_n    = phasedir;
    done_n   = 1'b0;
    llc_n    = lock_loss_cnt;

    unique case (state)
      ST_PLL_RST: begin
        if (timer == '0) begin
          state_n = ST_WAIT_LOCK;
          timer_n = T_LOCK;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          timer_n = T_LOCK;
        end else if (timer == '0) begin
          state_n = ST_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          sel_n = req_sel;
          dir_n = req_dir;
          if (req_count == 8'd0) begin
            done_n = 1'b1;
          end else begin
            state_n  = ST_SETUP;
            remain_n = req_count;
            timer_n  = T_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (timer == '0) begin
          state_n = ST_STEP;
          timer_n = T_HIGH;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_STEP: begin
        if (timer == '0) begin
          state_n = ST_GAP;
          timer_n = T_GAP;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer == '0) begin
          remain_n = remain - 8'd1;
          if (remain == 8'd1) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_STEP;
            timer_n = T_HIGH;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: begin
        state_n = ST_PLL_RST;
        timer_n = T_RST;
      end
    endcase

    // Lock loss wins over any pending handshake or completion in the same cycle.
    if (lock_lost) begin
      state_n  = ST_PLL_RST;
      timer_n  = T_RST;
      remain_n = 8'd0;
      sel_n    = phasesel;
      dir_n    = phasedir;
      done_n   = 1'b0;
      if (lock_loss_cnt != 8'hff) begin
        llc_n = lock_loss_cnt + 8'd1;
      end
    end
  end

endmodule
